sram_rdata_demux_16: RTL
========================

Name: sram_rdata_demux_16

Overview:
- Read-return side of the shared 16-requester SRAM port.
- Issue-side signals (sel_in, CEN, WEN) are driven by the 16:1 request mux. This block snoops them and tags every issued read with its requester index.
- It aligns the tag to the SRAM read latency, then steers the returned word Q to that requester's holding register with a one-cycle valid pulse.
- It also gives per-requester in-flight status, so NTT stage controllers can stall until their read data has landed.

Parameters:
- D_WIDTH, default `D_width, SRAM data word width.
- RD_LAT, default 1, SRAM clock-to-Q latency in cycles; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sel_in  input  4  requester index presented to the SRAM this cycle (same signal driven into the request mux).
- CEN  input  1  SRAM chip enable, active low.
- WEN  input  1  SRAM write enable: 1 = read, 0 = write.
- Q  input  D_WIDTH  SRAM read data, valid RD_LAT cycles after the issue cycle.
- Q_0 .. Q_15  output  D_WIDTH each  per-requester read-data holding registers.
- rvalid  output  16  one-hot per-requester pulse: the corresponding Q_k was updated this cycle.
- pending  output  16  bit k = 1 while at least one read for requester k is in flight.
- rd_cnt  output  16  free-running count of completed reads; wraps at 0xFFFF -> 0.

Behaviour:
- Read issue:
  - A read is issued in cycle c when CEN==0 && WEN==1 during c.
  - CEN==1, or CEN==0 with WEN==0 (write), produces no tag.
- Tag pipeline:
  - RD_LAT-stage shift register of {valid, sel[3:0]}.
  - Stage 0 loads {issue, sel_in} at the end of cycle c.
  - Each stage advances every cycle; there is no stall input.
  - Back-to-back reads every cycle are supported at full throughput.
- Return:
  - The last stage's tag is valid during cycle c+RD_LAT, coincident with valid Q.
  - At the end of that cycle, Q is registered into Q_sel.
  - rvalid[sel] = 1 during cycle c+RD_LAT+1. Total issue-to-rvalid latency is RD_LAT+1 cycles.
  - At most one rvalid bit is high per cycle; rvalid is 0 whenever no tag retires.
- Holding registers: Q_k keeps its value until the next retiring read for requester k. Writes never modify any Q_k.
- pending[k] = OR over all tag stages of (valid && sel==k), taken combinationally from the registered stages.
  - pending rises in cycle c+1 and falls in the cycle rvalid[k] asserts.
  - If the pipeline holds more than one read for k, pending stays high until the last one retires.
- Simultaneous events:
  - A new issue for k in the same cycle a tag for k retires: stage 0 loads the new tag and pending[k] stays 1.
  - Retire and issue for different requesters are independent.
- rd_cnt increments by 1 on each retiring read (the same edge that sets rvalid).
- Reset values: all tag valid bits 0, all Q_k 0, rvalid 0, pending 0, rd_cnt 0.
- Reset mid-operation:
  - rst==1 clears every in-flight tag; no rvalid is produced for reads issued before or during reset.
  - A read issued in the first cycle after rst deasserts is tagged normally.
- sel_in is only sampled when a read is issued; X on sel_in with no issue must not propagate.
- Parameter check: RD_LAT outside 1..4 triggers an elaboration-time $error.

Test Plan:
- Single read, RD_LAT=1: sel_in=5, CEN=0, WEN=1 in cycle 10; Q=0xA5A5 in cycle 11 -> rvalid=16'h0020 and Q_5=0xA5A5 in cycle 12; pending[5]=1 in cycle 11 only; rd_cnt=1.
- Back-to-back, RD_LAT=2: reads to sel 0,1,2,...,15 in consecutive cycles 0..15, Q=0x100+k returned in cycle k+2 -> rvalid one-hot bit k in cycle k+3 with Q_k=0x100+k; no gaps; rd_cnt=16.
- Writes and idle ignored: CEN=0, WEN=0, sel_in=3 and CEN=1, sel_in=7 with random Q -> rvalid stays 0, pending stays 0, Q_3 and Q_7 unchanged.
- Same-requester overlap, RD_LAT=3: reads to sel 9 in cycles 0 and 1 -> rvalid[9] in cycles 4 and 5, Q_9 takes the second word; pending[9] is high in cycles 1..4 and low from cycle 5.
- Reset mid-flight, RD_LAT=2: reads to sel 4 in cycle 0 and sel 6 in cycle 1; rst=1 in cycle 2 -> no rvalid in cycles 3..4, pending=0 from cycle 3, Q_4=Q_6=0; a read to sel 4 in cycle 3 returns normally in cycle 6.
- Counter wrap: preload traffic until rd_cnt=0xFFFF; one further read -> rd_cnt=0x0000 in its rvalid cycle.

Source files
------------

// File: rtl/sram_rdata_demux_16.sv
// Read-return demux for the shared 16-requester SRAM port.
// Tags issued reads, aligns them to RD_LAT and steers Q to per-requester registers.
`ifndef D_width
`define D_width 16
`endif

module sram_rdata_demux_16 #(
    parameter int D_WIDTH = `D_width,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         sel_in,
    input  logic               CEN,
    input  logic               WEN,
    input  logic [D_WIDTH-1:0] Q,
    output logic [D_WIDTH-1:0] Q_0,
    output logic [D_WIDTH-1:0] Q_1,
    output logic [D_WIDTH-1:0] Q_2,
    output logic [D_WIDTH-1:0] Q_3,
    output logic [D_WIDTH-1:0] Q_4,
    output logic [D_WIDTH-1:0] Q_5,
    output logic [D_WIDTH-1:0] Q_6,
    output logic [D_WIDTH-1:0] Q_7,
    output logic [D_WIDTH-1:0] Q_8,
    output logic [D_WIDTH-1:0] Q_9,
    output logic [D_WIDTH-1:0] Q_10,
    output logic [D_WIDTH-1:0] Q_11,
    output logic [D_WIDTH-1:0] Q_12,
    output logic [D_WIDTH-1:0] Q_13,
    output logic [D_WIDTH-1:0] Q_14,
    output logic [D_WIDTH-1:0] Q_15,
    output logic [15:0]        rvalid,
    output logic [15:0]        pending,
    output logic [15:0]        rd_cnt
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
        $error("sram_rdata_demux_16: RD_LAT must be within 1..4");
    end

    localparam int LAST = RD_LAT - 1;

    logic [RD_LAT-1:0]  tv_q;
    logic [3:0]         ts_q [RD_LAT];
    logic [D_WIDTH-1:0] hold_q [16];
    logic [15:0]        rvalid_q, rvalid_d;
    logic [15:0]        rd_cnt_q, rd_cnt_d;
    logic [15:0]        pending_d;
    logic               issue;
    logic [3:0]         sel_d;
    logic               retire;
    logic [3:0]         rsel;

    assign issue  = !CEN && WEN;
    // Gate the index so an undriven sel_in on idle cycles never enters the pipe.
    assign sel_d  = issue ? sel_in : 4'd0;
    assign retire = tv_q[LAST];
    assign rsel   = ts_q[LAST];

    always_comb begin
        rvalid_d = 16'd0;
        rd_cnt_d = rd_cnt_q;
        if (retire) begin
            rvalid_d = 16'h1 << rsel;
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_comb begin
        pending_d = 16'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (tv_q[i]) begin
                pending_d[ts_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tv_q     <= '0;
            rvalid_q <= 16'd0;
            rd_cnt_q <= 16'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                ts_q[i] <= 4'd0;
            end
            for (int k = 0; k < 16; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            tv_q[0]  <= issue;
            ts_q[0]  <= sel_d;
            for (int i = 1; i < RD_LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                ts_q[i] <= ts_q[i-1];
            end
            rvalid_q <= rvalid_d;
            rd_cnt_q <= rd_cnt_d;
            if (retire) begin
                hold_q[rsel] <= Q;
            end
        end
    end

    assign rvalid  = rvalid_q;
    assign pending = pending_d;
    assign rd_cnt  = rd_cnt_q;

    assign Q_0  = hold_q[0];
    assign Q_1  = hold_q[1];
    assign Q_2  = hold_q[2];
    assign Q_3  = hold_q[3];
    assign Q_4  = hold_q[4];
    assign Q_5  = hold_q[5];
    assign Q_6  = hold_q[6];
    assign Q_7  = hold_q[7];
    assign Q_8  = hold_q[8];
    assign Q_9  = hold_q[9];
    assign Q_10 = hold_q[10];
    assign Q_11 = hold_q[11];
    assign Q_12 = hold_q[12];
    assign Q_13 = hold_q[13];
    assign Q_14 = hold_q[14];
    assign Q_15 = hold_q[15];

endmodule
